exec_cond_mem_stage: RTL and testbench

- Execute-side consumer of the decode/execute pipeline register outputs.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field of the instruction currently in execute against it.
- Gates the instruction's side effects (PC write, register write, memory write, flag update) by the condition result.
- Latches the gated controls and datapath values into the execute/memory pipeline register, with stall and flush support.

---
 rtl/exec_cond_mem_stage_if.sv | 47 ++++
 rtl/exec_cond_mem_stage.sv | 100 ++++++++++
 tb/tb_exec_cond_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_cond_mem_stage_if.sv
// Execute-to-memory stage bus.
// Carries the execute-side instruction controls and datapath values into the
// stage, and the condition result, flag state and M-register contents out.
//   slave  : the stage itself (consumes E-side and stall/flush, drives results)
//   master : whatever drives the execute side and observes the results
interface exec_cond_mem_stage_if #(
    parameter int SIZE = 32
);
    logic            StallM;
    logic            FlushM;
    logic            PCSrcE;
    logic            RegWriteE;
    logic            MemToRegE;
    logic            MemWriteE;
    logic            BranchE;
    logic [1:0]      FlagWriteE;
    logic [3:0]      CondE;
    logic [3:0]      ALUFlagsE;
    logic [SIZE-1:0] ALUResultE;
    logic [SIZE-1:0] WriteDataE;
    logic [4:0]      WA3E;

    logic            CondExE;
    logic            BranchTakenE;
    logic [3:0]      FlagsQ;
    logic            PCSrcM;
    logic            RegWriteM;
    logic            MemToRegM;
    logic            MemWriteM;
    logic [SIZE-1:0] ALUResultM;
    logic [SIZE-1:0] WriteDataM;
    logic [4:0]      WA3M;

    modport slave (
        input  StallM, FlushM, PCSrcE, RegWriteE, MemToRegE, MemWriteE, BranchE,
               FlagWriteE, CondE, ALUFlagsE, ALUResultE, WriteDataE, WA3E,
        output CondExE, BranchTakenE, FlagsQ, PCSrcM, RegWriteM, MemToRegM,
               MemWriteM, ALUResultM, WriteDataM, WA3M
    );

    modport master (
        output StallM, FlushM, PCSrcE, RegWriteE, MemToRegE, MemWriteE, BranchE,
               FlagWriteE, CondE, ALUFlagsE, ALUResultE, WriteDataE, WA3E,
        input  CondExE, BranchTakenE, FlagsQ, PCSrcM, RegWriteM, MemToRegM,
               MemWriteM, ALUResultM, WriteDataM, WA3M
    );
endinterface

// File: rtl/exec_cond_mem_stage.sv
// Execute-side condition stage and execute/memory pipeline register.
// Holds the NZCV flag register, evaluates the execute instruction's condition
// field against it, gates the instruction's side effects with the result and
// registers the gated controls and data into the M stage.
// Ports:
//   CLK : system clock, rising-edge
//   CLR : asynchronous active-high clear of flags and all M-side state
//   bus : exec_cond_mem_stage_if.slave (E-side inputs, stall/flush, results)
module exec_cond_mem_stage #(
    parameter int SIZE = 32
) (
    input  logic                   CLK,
    input  logic                   CLR,
    exec_cond_mem_stage_if.slave   bus
);

    logic [3:0]      flags_q;
    logic            cond_ex;
    logic            n_f, z_f, c_f, v_f;

    logic            pc_src_m, reg_write_m, mem_to_reg_m, mem_write_m;
    logic [SIZE-1:0] alu_result_m, write_data_m;
    logic [4:0]      wa3_m;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Condition uses the registered (pre-update) flags only; there is no
    // bypass from ALUFlagsE.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.CondE)
            4'h0:    cond_ex = z_f;
            4'h1:    cond_ex = ~z_f;
            4'h2:    cond_ex = c_f;
            4'h3:    cond_ex = ~c_f;
            4'h4:    cond_ex = n_f;
            4'h5:    cond_ex = ~n_f;
            4'h6:    cond_ex = v_f;
            4'h7:    cond_ex = ~v_f;
            4'h8:    cond_ex = c_f & ~z_f;
            4'h9:    cond_ex = ~c_f | z_f;
            4'hA:    cond_ex = (n_f == v_f);
            4'hB:    cond_ex = (n_f != v_f);
            4'hC:    cond_ex = ~z_f & (n_f == v_f);
            4'hD:    cond_ex = z_f | (n_f != v_f);
            4'hE:    cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag register: a squashed, stalled or condition-failed instruction
    // never touches the flags. N,Z and C,V have independent write enables.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            flags_q <= 4'b0000;
        end else if (~bus.StallM & ~bus.FlushM & cond_ex) begin
            if (bus.FlagWriteE[1]) flags_q[3:2] <= bus.ALUFlagsE[3:2];
            if (bus.FlagWriteE[0]) flags_q[1:0] <= bus.ALUFlagsE[1:0];
        end
    end

    // M register. Flush zeroes the controls but leaves the data fields alone;
    // a failed condition still loads, carrying zeroed gated controls.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc_src_m     <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            alu_result_m <= '0;
            write_data_m <= '0;
            wa3_m        <= 5'd0;
        end else if (bus.FlushM) begin
            pc_src_m     <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
        end else if (~bus.StallM) begin
            pc_src_m     <= bus.PCSrcE & cond_ex;
            reg_write_m  <= bus.RegWriteE & cond_ex;
            mem_to_reg_m <= bus.MemToRegE;
            mem_write_m  <= bus.MemWriteE & cond_ex;
            alu_result_m <= bus.ALUResultE;
            write_data_m <= bus.WriteDataE;
            wa3_m        <= bus.WA3E;
        end
    end

    assign bus.CondExE      = cond_ex;
    assign bus.BranchTakenE = bus.BranchE & cond_ex & ~bus.FlushM;
    assign bus.FlagsQ       = flags_q;
    assign bus.PCSrcM       = pc_src_m;
    assign bus.RegWriteM    = reg_write_m;
    assign bus.MemToRegM    = mem_to_reg_m;
    assign bus.MemWriteM    = mem_write_m;
    assign bus.ALUResultM   = alu_result_m;
    assign bus.WriteDataM   = write_data_m;
    assign bus.WA3M         = wa3_m;

endmodule

// File: tb/tb_exec_cond_mem_stage.sv
// Self-checking bench for exec_cond_mem_stage: directed sequences, a table of
// condition vectors, a full condition/flag sweep and a randomized run against
// a behavioural model of the stage.
module tb_exec_cond_mem_stage;
    localparam int SIZE = 32;

    logic CLK;
    logic CLR;
    int   checks;
    int   failures;

    exec_cond_mem_stage_if #(.SIZE(SIZE)) bus ();

    exec_cond_mem_stage #(.SIZE(SIZE)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t tbl[14];

    // Conditions come in complementary pairs: even code is the base test,
    // the odd code its inverse (AL/never included).
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.StallM     = 1'b0;
        bus.FlushM     = 1'b0;
        bus.PCSrcE     = 1'b0;
        bus.RegWriteE  = 1'b0;
        bus.MemToRegE  = 1'b0;
        bus.MemWriteE  = 1'b0;
        bus.BranchE    = 1'b0;
        bus.FlagWriteE = 2'b00;
        bus.CondE      = 4'hE;
        bus.ALUFlagsE  = 4'h0;
        bus.ALUResultE = '0;
        bus.WriteDataE = '0;
        bus.WA3E       = 5'd0;
    endtask

    task automatic rand_inputs();
        bus.PCSrcE     = 1'($urandom);
        bus.RegWriteE  = 1'($urandom);
        bus.MemToRegE  = 1'($urandom);
        bus.MemWriteE  = 1'($urandom);
        bus.BranchE    = 1'($urandom);
        bus.FlagWriteE = 2'($urandom);
        bus.CondE      = 4'($urandom);
        bus.ALUFlagsE  = 4'($urandom);
        bus.ALUResultE = $urandom;
        bus.WriteDataE = $urandom;
        bus.WA3E       = 5'($urandom);
    endtask

    task automatic load_flags(input logic [3:0] f);
        idle();
        bus.FlagWriteE = 2'b11;
        bus.ALUFlagsE  = f;
        tick();
    endtask

    // Behavioural model state
    logic [3:0]      m_flags;
    logic [3:0]      m_ctl;    // {PCSrc, RegWrite, MemToReg, MemWrite}
    logic [SIZE-1:0] m_alu, m_wd;
    logic [4:0]      m_wa;

    initial begin
        checks   = 0;
        failures = 0;
        idle();

        // Reset with random inputs applied
        CLR = 1'b1;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        chk("rst_flags", SIZE'(bus.FlagsQ), 0);
        chk("rst_regwrite", SIZE'(bus.RegWriteM), 0);
        chk("rst_memwrite", SIZE'(bus.MemWriteM), 0);
        chk("rst_aluresult", bus.ALUResultM, 0);
        chk("rst_wa3", SIZE'(bus.WA3M), 0);
        CLR = 1'b0;
        idle();
        bus.ALUResultE = 32'h1234;
        bus.RegWriteE  = 1'b1;
        tick();
        chk("first_load_regwrite", SIZE'(bus.RegWriteM), 1);
        chk("first_load_alu", bus.ALUResultM, 32'h1234);

        // Flag update then use in the following cycles
        idle();
        bus.FlagWriteE = 2'b11;
        bus.ALUFlagsE  = 4'b0100;
        tick();
        chk("flag_z_set", SIZE'(bus.FlagsQ), 4'b0100);
        idle();
        bus.CondE   = 4'h0;
        bus.BranchE = 1'b1;
        bus.PCSrcE  = 1'b1;
        #1;
        chk("eq_condex", SIZE'(bus.CondExE), 1);
        chk("eq_branchtaken", SIZE'(bus.BranchTakenE), 1);
        tick();
        chk("eq_pcsrcm", SIZE'(bus.PCSrcM), 1);
        idle();
        bus.CondE     = 4'h1;
        bus.RegWriteE = 1'b1;
        #1;
        chk("ne_condex", SIZE'(bus.CondExE), 0);
        tick();
        chk("ne_regwritem", SIZE'(bus.RegWriteM), 0);

        // Partial flag write and failed condition
        load_flags(4'b1000);
        idle();
        bus.FlagWriteE = 2'b01;
        bus.ALUFlagsE  = 4'b0111;
        tick();
        chk("partial_cv", SIZE'(bus.FlagsQ), 4'b1011);
        idle();
        bus.CondE      = 4'h0;
        bus.FlagWriteE = 2'b11;
        bus.ALUFlagsE  = 4'b0100;
        bus.RegWriteE  = 1'b1;
        bus.MemWriteE  = 1'b1;
        bus.PCSrcE     = 1'b1;
        bus.MemToRegE  = 1'b1;
        bus.ALUResultE = 32'hABCD;
        tick();
        chk("failed_cond_flags", SIZE'(bus.FlagsQ), 4'b1011);
        chk("failed_cond_ctl", SIZE'({bus.PCSrcM, bus.RegWriteM, bus.MemToRegM, bus.MemWriteM}), 4'b0010);
        chk("failed_cond_alu", bus.ALUResultM, 32'hABCD);

        // Stall holds M and flags
        idle();
        bus.WA3E      = 5'd5;
        bus.RegWriteE = 1'b1;
        tick();
        chk("stall_preload_wa3", SIZE'(bus.WA3M), 5);
        for (int i = 0; i < 3; i++) begin
            bus.StallM     = 1'b1;
            bus.WA3E       = 5'(i + 10);
            bus.ALUResultE = 32'(i + 100);
            bus.FlagWriteE = 2'b11;
            bus.ALUFlagsE  = 4'(i + 1);
            tick();
            chk("stall_wa3", SIZE'(bus.WA3M), 5);
            chk("stall_flags", SIZE'(bus.FlagsQ), 4'b1011);
        end

        // Flush beats stall; no flag update, data fields hold
        idle();
        bus.StallM     = 1'b1;
        bus.FlushM     = 1'b1;
        bus.RegWriteE  = 1'b1;
        bus.MemWriteE  = 1'b1;
        bus.BranchE    = 1'b1;
        bus.FlagWriteE = 2'b11;
        bus.ALUFlagsE  = 4'b0100;
        bus.WA3E       = 5'd9;
        #1;
        chk("flush_branchtaken", SIZE'(bus.BranchTakenE), 0);
        tick();
        chk("flush_regwrite", SIZE'(bus.RegWriteM), 0);
        chk("flush_memwrite", SIZE'(bus.MemWriteM), 0);
        chk("flush_flags", SIZE'(bus.FlagsQ), 4'b1011);
        chk("flush_wa3_hold", SIZE'(bus.WA3M), 5);

        // Clear while stalled, then a normal load
        idle();
        bus.StallM = 1'b1;
        tick();
        CLR = 1'b1;
        #1;
        chk("clr_midstall_wa3", SIZE'(bus.WA3M), 0);
        chk("clr_midstall_flags", SIZE'(bus.FlagsQ), 0);
        tick();
        CLR = 1'b0;
        idle();
        bus.WA3E      = 5'd7;
        bus.RegWriteE = 1'b1;
        tick();
        chk("post_clr_wa3", SIZE'(bus.WA3M), 7);
        chk("post_clr_regwrite", SIZE'(bus.RegWriteM), 1);

        // Condition table (hand-derived expectations)
        tbl[0]  = '{4'b1000, 4'hA, 1'b0};
        tbl[1]  = '{4'b1000, 4'hB, 1'b1};
        tbl[2]  = '{4'b1000, 4'hC, 1'b0};
        tbl[3]  = '{4'b1000, 4'hD, 1'b1};
        tbl[4]  = '{4'b1000, 4'hF, 1'b0};
        tbl[5]  = '{4'b1111, 4'hF, 1'b0};
        tbl[6]  = '{4'b0100, 4'h0, 1'b1};
        tbl[7]  = '{4'b0100, 4'h1, 1'b0};
        tbl[8]  = '{4'b0010, 4'h8, 1'b1};
        tbl[9]  = '{4'b0010, 4'h9, 1'b0};
        tbl[10] = '{4'b0110, 4'h8, 1'b0};
        tbl[11] = '{4'b0110, 4'h9, 1'b1};
        tbl[12] = '{4'b1001, 4'hC, 1'b1};
        tbl[13] = '{4'b0000, 4'hE, 1'b1};
        for (int i = 0; i < 14; i++) begin
            load_flags(tbl[i].flags);
            bus.FlagWriteE = 2'b00;
            bus.CondE      = tbl[i].cond;
            #1;
            chk($sformatf("tbl%0d_condex", i), SIZE'(bus.CondExE), SIZE'(tbl[i].exp));
        end

        // Full sweep of condition codes against every flag value
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            bus.FlagWriteE = 2'b00;
            for (int c = 0; c < 16; c++) begin
                bus.CondE = 4'(c);
                #1;
                chk($sformatf("sweep_f%0h_c%0h", f, c), SIZE'(bus.CondExE),
                    SIZE'(cond_ref(4'(c), 4'(f))));
            end
        end

        // Randomized run against the model
        idle();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        m_flags = 4'h0;
        m_ctl   = 4'h0;
        m_alu   = '0;
        m_wd    = '0;
        m_wa    = 5'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 39) == 0) begin
                rand_inputs();
                CLR = 1'b1;
                #1;
                m_flags = 4'h0;
                m_ctl   = 4'h0;
                m_alu   = '0;
                m_wd    = '0;
                m_wa    = 5'd0;
                chk("rnd_clr_flags", SIZE'(bus.FlagsQ), SIZE'(m_flags));
                chk("rnd_clr_alu", bus.ALUResultM, m_alu);
                tick();
                CLR = 1'b0;
            end else begin
                logic ce;
                rand_inputs();
                bus.StallM = ($urandom_range(0, 3) == 0);
                bus.FlushM = ($urandom_range(0, 5) == 0);
                #2;
                ce = cond_ref(bus.CondE, m_flags);
                chk("rnd_condex", SIZE'(bus.CondExE), SIZE'(ce));
                chk("rnd_branchtaken", SIZE'(bus.BranchTakenE),
                    SIZE'(bus.BranchE && ce && !bus.FlushM));
                if (!bus.StallM && !bus.FlushM && ce) begin
                    if (bus.FlagWriteE[1]) m_flags[3:2] = bus.ALUFlagsE[3:2];
                    if (bus.FlagWriteE[0]) m_flags[1:0] = bus.ALUFlagsE[1:0];
                end
                if (bus.FlushM) begin
                    m_ctl = 4'h0;
                end else if (!bus.StallM) begin
                    m_ctl = {bus.PCSrcE && ce, bus.RegWriteE && ce, bus.MemToRegE, bus.MemWriteE && ce};
                    m_alu = bus.ALUResultE;
                    m_wd  = bus.WriteDataE;
                    m_wa  = bus.WA3E;
                end
                tick();
                chk("rnd_flags", SIZE'(bus.FlagsQ), SIZE'(m_flags));
                chk("rnd_ctl", SIZE'({bus.PCSrcM, bus.RegWriteM, bus.MemToRegM, bus.MemWriteM}), SIZE'(m_ctl));
                chk("rnd_alu", bus.ALUResultM, m_alu);
                chk("rnd_wd", bus.WriteDataM, m_wd);
                chk("rnd_wa3", SIZE'(bus.WA3M), SIZE'(m_wa));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
